// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall-vector driven bubble/hold control and occupancy counters.
// Define PIPE_STAGE_SKID_EN to add a skid slot that registers in_ready and keeps full throughput.
module pipe_stage_reg #(
    parameter int PAYLOAD_W = 110,
    parameter int STAGE_IDX = 3,
    parameter int STALL_W   = 6,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     hold_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic stop_here;
    logic stop_next;
    logic bubble;
    logic hold;
    logic accept;
    logic drain;
    logic unused_stall;

    assign stop_here = stall[STAGE_IDX];

    generate
        if (STAGE_IDX + 1 < STALL_W) begin : g_next
            assign stop_next = stall[STAGE_IDX+1];
        end else begin : g_last
            assign stop_next = 1'b0;
        end
    endgenerate

    // Only two bits of the stall vector matter to this stage.
    assign unused_stall = ^stall;

    assign bubble = stop_here & ~stop_next;
    assign hold   = stop_here & stop_next;

    logic                 slot_vld_p1;
    logic [PAYLOAD_W-1:0] slot_payload_p1;

    assign out_valid   = slot_vld_p1;
    assign out_payload = slot_payload_p1;

    assign accept = in_valid & in_ready;
    assign drain  = slot_vld_p1 & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                 skid_vld_p0;
    logic [PAYLOAD_W-1:0] skid_payload_p0;

    assign in_ready = rst & ~skid_vld_p0 & ~stop_here & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_vld_p1     <= 1'b0;
            slot_payload_p1 <= '0;
            skid_vld_p0     <= 1'b0;
            skid_payload_p0 <= '0;
            bubble_cnt      <= '0;
            hold_cnt        <= '0;
        end else if (flush) begin
            slot_vld_p1     <= 1'b0;
            slot_payload_p1 <= '0;
            skid_vld_p0     <= 1'b0;
            skid_payload_p0 <= '0;
        end else if (bubble) begin
            slot_vld_p1     <= 1'b0;
            slot_payload_p1 <= '0;
            bubble_cnt      <= sat_inc(bubble_cnt);
        end else if (hold) begin
            hold_cnt        <= sat_inc(hold_cnt);
        end else if (!slot_vld_p1 || drain) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_vld_p0) begin
                slot_vld_p1     <= 1'b1;
                slot_payload_p1 <= skid_payload_p0;
                skid_vld_p0     <= accept;
                skid_payload_p0 <= accept ? in_payload : '0;
            end else begin
                slot_vld_p1     <= accept;
                slot_payload_p1 <= accept ? in_payload : '0;
            end
        end else if (accept) begin
            skid_vld_p0     <= 1'b1;
            skid_payload_p0 <= in_payload;
        end
    end
`else
    assign in_ready = rst & (~slot_vld_p1 | out_ready) & ~stop_here & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_vld_p1     <= 1'b0;
            slot_payload_p1 <= '0;
            bubble_cnt      <= '0;
            hold_cnt        <= '0;
        end else if (flush) begin
            slot_vld_p1     <= 1'b0;
            slot_payload_p1 <= '0;
        end else if (bubble) begin
            slot_vld_p1     <= 1'b0;
            slot_payload_p1 <= '0;
            bubble_cnt      <= sat_inc(bubble_cnt);
        end else if (hold) begin
            hold_cnt        <= sat_inc(hold_cnt);
        end else if (!slot_vld_p1 || drain) begin
            slot_vld_p1     <= accept;
            slot_payload_p1 <= accept ? in_payload : '0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, back-pressure, bubble, hold, flush and reset.
// Counters are built 2 bits wide so hold saturation is reachable in a few cycles.
module tb_pipe_stage_reg;

    localparam int PAYLOAD_W = 110;
    localparam int STALL_W   = 6;
    localparam int CNT_W     = 2;

    logic                 clk;
    logic                 rst;
    logic [STALL_W-1:0]   stall;
    logic                 flush;
    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_ready;
    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_ready;
    logic [CNT_W-1:0]     bubble_cnt;
    logic [CNT_W-1:0]     hold_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(
        .PAYLOAD_W(PAYLOAD_W),
        .STAGE_IDX(3),
        .STALL_W  (STALL_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_payload (in_payload),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_payload(out_payload),
        .out_ready  (out_ready),
        .bubble_cnt (bubble_cnt),
        .hold_cnt   (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [127:0] pay);
        chk({tag, "_vld"}, 128'(out_valid), 128'(vld));
        chk({tag, "_pay"}, 128'(out_payload), pay);
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0;
        in_valid = 1'b0; in_payload = '0; out_ready = 1'b0;
        tick();
        chk_out("reset", 1'b0, 0);
        chk("reset_bubble", 128'(bubble_cnt), 0);
        chk("reset_hold", 128'(hold_cnt), 0);
        chk("reset_rdy", 128'(in_ready), 0);

        // Streaming 1..8 with no gaps
        rst = 1'b1; in_valid = 1'b1; in_payload = PAYLOAD_W'(1); out_ready = 1'b1;
        #1;
        chk("first_rdy", 128'(in_ready), 1);
        for (int i = 1; i <= 8; i++) begin
            in_payload = PAYLOAD_W'(i);
            tick();
            chk_out("stream", 1'b1, 128'(i));
        end
        in_valid = 1'b0;
        tick();
        chk_out("stream_end", 1'b0, 0);

        // Bubble: stage stops, next stage runs
        in_valid = 1'b1; in_payload = PAYLOAD_W'(5); out_ready = 1'b0;
        tick();
        chk_out("load5", 1'b1, 5);
        in_valid = 1'b0; stall = 6'b001000;
        #1;
        chk("bubble_rdy", 128'(in_ready), 0);
        tick();
        chk_out("bubble1", 1'b0, 0);
        chk("bubble1_cnt", 128'(bubble_cnt), 1);
        tick();
        chk_out("bubble2", 1'b0, 0);
        chk("bubble2_cnt", 128'(bubble_cnt), 2);
        chk("bubble2_rdy", 128'(in_ready), 0);

        // Hold: both stages stopped, outputs frozen even with out_ready high
        stall = '0; in_valid = 1'b1; in_payload = PAYLOAD_W'(5);
        #1;
        chk("reload_rdy", 128'(in_ready), 1);
        tick();
        chk_out("reload5", 1'b1, 5);
        in_valid = 1'b0; out_ready = 1'b1; stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("hold", 1'b1, 5);
        end
        chk("hold_cnt3", 128'(hold_cnt), 3);
        chk("hold_bubble_kept", 128'(bubble_cnt), 2);
        chk("hold_rdy", 128'(in_ready), 0);
        tick();
        chk("hold_sat", 128'(hold_cnt), 3);
        chk_out("hold_sat", 1'b1, 5);
        stall = '0;
        tick();
        chk_out("hold_drain", 1'b0, 0);

        // Back-pressure: 0xA, 0xB, 0xC with out_ready low for 3 cycles
        in_valid = 1'b1; in_payload = PAYLOAD_W'('hA); out_ready = 1'b0;
        tick();
        chk_out("bp_a", 1'b1, 'hA);
`ifdef PIPE_STAGE_SKID_EN
        in_payload = PAYLOAD_W'('hB);
        #1;
        chk("bp_rdy_b", 128'(in_ready), 1);
        tick();
        chk_out("bp_hold1", 1'b1, 'hA);
        chk("bp_rdy_full", 128'(in_ready), 0);
        in_payload = PAYLOAD_W'('hC);
        tick();
        chk_out("bp_hold2", 1'b1, 'hA);
        tick();
        chk_out("bp_hold3", 1'b1, 'hA);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_reg", 128'(in_ready), 0);
        tick();
        chk_out("bp_b", 1'b1, 'hB);
        chk("bp_rdy_free", 128'(in_ready), 1);
`else
        in_payload = PAYLOAD_W'('hB);
        #1;
        chk("bp_rdy_b", 128'(in_ready), 0);
        tick();
        chk_out("bp_hold2", 1'b1, 'hA);
        tick();
        chk_out("bp_hold3", 1'b1, 'hA);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", 128'(in_ready), 1);
        tick();
        chk_out("bp_b", 1'b1, 'hB);
        in_payload = PAYLOAD_W'('hC);
`endif
        tick();
        chk_out("bp_c", 1'b1, 'hC);
        in_valid = 1'b0;
        tick();
        chk_out("bp_empty", 1'b0, 0);

        // Flush with entries held; counters survive
        in_valid = 1'b1; in_payload = PAYLOAD_W'('h11); out_ready = 1'b0;
        tick();
        chk_out("fl_11", 1'b1, 'h11);
        in_payload = PAYLOAD_W'('h22);
        tick();
        chk_out("fl_held", 1'b1, 'h11);
        in_valid = 1'b0; flush = 1'b1;
        #1;
        chk("fl_rdy_during", 128'(in_ready), 0);
        tick();
        chk_out("flushed", 1'b0, 0);
        chk("fl_bubble_kept", 128'(bubble_cnt), 2);
        chk("fl_hold_kept", 128'(hold_cnt), 3);
        flush = 1'b0;
        #1;
        chk("fl_rdy_after", 128'(in_ready), 1);
        out_ready = 1'b1;
        tick();
        chk_out("fl_no_skid", 1'b0, 0);

        // Reset mid-transfer, then accept on the first edge after release
        in_valid = 1'b1; in_payload = PAYLOAD_W'('h33);
        tick();
        chk_out("rs_33", 1'b1, 'h33);
        rst = 1'b0;
        #1;
        chk("rs_rdy", 128'(in_ready), 0);
        tick();
        chk_out("rs_clear", 1'b0, 0);
        chk("rs_bubble", 128'(bubble_cnt), 0);
        chk("rs_hold", 128'(hold_cnt), 0);
        rst = 1'b1; in_payload = PAYLOAD_W'('h44);
        tick();
        chk_out("rs_first", 1'b1, 'h44);
        in_valid = 1'b0;
        tick();
        chk_out("rs_drain", 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 110, width of the packed stage payload (aluop, mem addr/data, write addr/en/data).
REQ-002 Parameter STAGE_IDX, default 3, index of this stage's bit in the stall vector.
REQ-003 Parameter STALL_W, default 6, stall vector width.
REQ-004 Parameter CNT_W, default 16, width of the occupancy statistics counters.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-007 stall  in  STALL_W  pipeline stall vector, 1 = stop.
REQ-008 flush  in  1  discard all held entries.
REQ-009 in_valid  in  1  upstream entry present.
REQ-010 in_payload  in  PAYLOAD_W  upstream entry.
REQ-011 in_ready  out  1  stage accepts an entry this cycle.
REQ-012 out_valid  out  1  registered entry valid.
REQ-013 out_payload  out  PAYLOAD_W  registered entry; all-zero (NOP) when out_valid=0.
REQ-014 out_ready  in  1  downstream consumes the entry this cycle.
REQ-015 bubble_cnt  out  CNT_W  count of bubble-insert cycles.
REQ-016 hold_cnt  out  CNT_W  count of hold cycles.

Function
REQ-017 stop_here SHALL be stall[STAGE_IDX]; stop_next SHALL be stall[STAGE_IDX+1], or 0 when STAGE_IDX+1 >= STALL_W.
REQ-018 Per-cycle priority SHALL be: reset > flush > bubble (stop_here & !stop_next) > hold (stop_here & stop_next) > handshake.
REQ-019 Accept SHALL occur when in_valid & in_ready; drain SHALL occur when out_valid & out_ready.
REQ-020 in_ready SHALL be 0 whenever stop_here=1 or flush=1.
REQ-021 Flush SHALL clear every slot: out_valid=0, out_payload=0, skid slot empty, on the next edge.
REQ-022 Bubble SHALL set out_valid=0 and out_payload=0 on the next edge, retain the skid slot, and increment bubble_cnt.
REQ-023 Hold SHALL keep all slots and outputs unchanged and increment hold_cnt.
REQ-024 In handshake mode, latency in_payload -> out_payload SHALL be exactly 1 cycle when the output slot is empty or draining.
REQ-025 Drain without accept SHALL clear out_valid and zero out_payload, unless a skid entry exists, which SHALL move to the output slot.
REQ-026 Simultaneous accept and drain SHALL load the new entry (or the skid entry, preserving order) with no bubble; entry order SHALL never change.
REQ-027 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT be cleared by flush.
REQ-028 No entry SHALL be duplicated or lost except by flush or bubble-cleared output slot.

Reset
REQ-029 On rst=0 at an edge: out_valid=0, out_payload=0, skid slot empty, bubble_cnt=0, hold_cnt=0; in_ready SHALL be 0 while rst=0.
REQ-030 Reset mid-transfer SHALL discard all entries; the first accept SHALL be possible on the first edge after rst returns to 1.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN defined: one output slot plus one skid slot; in_ready = !skid_valid & !stop_here & !flush, purely registered state (no out_ready combinational path); full throughput under back-pressure.
REQ-032 Macro undefined: single output slot, no skid; in_ready = (!out_valid | out_ready) & !stop_here & !flush (combinational from out_ready).

Verification
REQ-033 Streaming: in_valid=1 payloads 1..8, out_ready=1, stall=0 -> out_payload 1..8 one per cycle from cycle 1, no gaps.
REQ-034 Back-pressure (SKID_EN): stream 0xA,0xB,0xC, out_ready=0 for 3 cycles -> in_ready falls after 2 entries, 0xA held, 0xC not accepted; on release 0xA,0xB,0xC exit in order.
REQ-035 Bubble: stall=6'b001000 for 2 cycles with entry 0x5 held -> out_valid=0, out_payload=0, bubble_cnt=2, in_ready=0.
REQ-036 Hold: stall=6'b011000 for 3 cycles -> outputs frozen on 0x5, hold_cnt=3, bubble_cnt unchanged.
REQ-037 Flush/reset: flush=1 with two entries held -> next cycle out_valid=0, in_ready=1, counters kept; rst=0 -> all outputs and counters 0.
